// File: rtl/jtsdram_pkg.sv
// Shared types and constants for the SDRAM read checker: FSM states,
// LFSR seed/taps and the WAIT watchdog limit.
package jtsdram_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [21:0] LFSR_SEED   = 22'h00_0001;
  localparam int          LFSR_TAP_HI = 21;
  localparam int          LFSR_TAP_LO = 20;
  localparam logic [7:0]  TIMEOUT_MAX = 8'd255;

  // Fibonacci shift-left step; the seed is non-zero so the all-zero lock-up state is never reached
  function automatic logic [21:0] lfsr_next(input logic [21:0] a);
    return {a[20:0], a[LFSR_TAP_HI] ^ a[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/jtsdram_addrgen.sv
// Address register for the read checker: linear or LFSR sequence,
// with the mode captured when the first address is loaded.
module jtsdram_addrgen
  import jtsdram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_adv,
  input  logic        i_rnd,
  output logic [21:0] o_addr
);

  logic [21:0] r_addr;
  logic        r_mode;

  // Load picks the first address for the requested mode; advance steps it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= 22'd0;
      r_mode <= 1'b0;
    end else if (i_load) begin
      r_mode <= i_rnd;
      r_addr <= i_rnd ? LFSR_SEED : 22'd0;
    end else if (i_adv) begin
      r_addr <= r_mode ? lfsr_next(r_addr) : r_addr + 22'd1;
    end else begin
      r_addr <= r_addr;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/jtsdram_rdcheck.sv
// SDRAM read-sequence generator and checker feeding jtsdram_shuffle.
// Optional WAIT watchdog enabled by defining JTSDRAM_TIMEOUT_EN.
module jtsdram_rdcheck
  import jtsdram_pkg::*;
#(
  parameter logic [21:0] LAST = 22'h3F_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rnd,
  output logic [21:0] addr,
  output logic [15:0] ref_raw,
  input  logic [15:0] ref_shf,
  output logic        rd,
  input  logic        ack,
  input  logic        rdy,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic        bad,
  output logic [15:0] err_cnt
);

  state_t      r_state, w_next;
  logic        w_load, w_adv, w_check, w_fin, w_miss;
  logic [21:0] w_addr;
  logic [21:0] r_cnt;
  logic [15:0] r_ref_q, r_err_cnt;
  logic        r_bad, r_rd, r_busy, r_done;

  jtsdram_addrgen u_addrgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_adv  (w_adv),
    .i_rnd  (rnd),
    .o_addr (w_addr)
  );

  assign addr    = w_addr;
  assign ref_raw = w_addr[15:0] ^ {10'd0, w_addr[21:16]};

`ifdef JTSDRAM_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       w_tmo;

  assign w_tmo  = (r_state == WAIT) && !rdy && (r_wdog == TIMEOUT_MAX);
  assign w_fin  = rdy || w_tmo;
  // A timed-out read has no data to compare and always counts as a miss
  assign w_miss = rdy ? (din != r_ref_q) : 1'b1;

  // Watchdog: cleared on entry to WAIT, counts WAIT cycles without data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= 8'd0;
    end else if (r_state != WAIT) begin
      r_wdog <= 8'd0;
    end else if (!rdy && (r_wdog != TIMEOUT_MAX)) begin
      r_wdog <= r_wdog + 8'd1;
    end else begin
      r_wdog <= r_wdog;
    end
  end
`else
  assign w_fin  = rdy;
  assign w_miss = (din != r_ref_q);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and per-cycle strobes
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_adv   = 1'b0;
    w_check = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = ADDR;
        end else begin
          w_next = IDLE;
        end
      end
      ADDR: w_next = REQ;
      REQ: begin
        if (ack) w_next = WAIT;
        else     w_next = REQ;
      end
      WAIT: begin
        if (w_fin) begin
          w_check = 1'b1;
          if (r_cnt == LAST) begin
            w_next = DONE;
          end else begin
            w_adv  = 1'b1;
            w_next = ADDR;
          end
        end else begin
          w_next = WAIT;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: reference capture, read counter and error accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_q   <= 16'd0;
      r_cnt     <= 22'd0;
      r_bad     <= 1'b0;
      r_err_cnt <= 16'd0;
    end else begin
      if (r_state == ADDR) r_ref_q <= ref_shf;
      else                 r_ref_q <= r_ref_q;

      if (w_load)     r_cnt <= 22'd0;
      else if (w_adv) r_cnt <= r_cnt + 22'd1;
      else            r_cnt <= r_cnt;

      if (w_load) begin
        r_bad     <= 1'b0;
        r_err_cnt <= 16'd0;
      end else if (w_check && w_miss) begin
        r_bad     <= 1'b1;
        r_err_cnt <= (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
      end else begin
        r_bad     <= r_bad;
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  // Control outputs registered from the next state so they track the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_rd   <= (w_next == REQ);
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
    end
  end

  assign rd      = r_rd;
  assign busy    = r_busy;
  assign done    = r_done;
  assign bad     = r_bad;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_jtsdram_rdcheck.sv
// Directed self-checking bench for jtsdram_rdcheck (LAST=3) with a simple
// shuffler and memory model; timeout case runs when JTSDRAM_TIMEOUT_EN is set.
module tb_jtsdram_rdcheck;

  logic        clk = 1'b0;
  logic        rst_n, start, rnd, rd, ack, rdy, busy, done, bad;
  logic [21:0] addr;
  logic [15:0] ref_raw, ref_shf, din, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] shuf(input logic [21:0] a);
    logic [15:0] raw;
    raw = a[15:0] ^ {10'd0, a[21:16]};
    return {raw[7:0], raw[15:8]} ^ 16'h5A3C;
  endfunction

  assign ref_shf = shuf(addr);

  jtsdram_rdcheck #(.LAST(22'd3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rnd(rnd),
    .addr(addr), .ref_raw(ref_raw), .ref_shf(ref_shf),
    .rd(rd), .ack(ack), .rdy(rdy), .din(din),
    .busy(busy), .done(done), .bad(bad), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // memory model knobs
  int   ack_dly    = 0;
  int   hold_idx   = -1;
  int   rd_idx     = 0;
  bit   corrupt_en = 1'b0;
  int   req_wait   = 0;
  bit   pending    = 1'b0;

  initial begin
    ack = 1'b0; rdy = 1'b0; din = 16'd0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      rdy = 1'b0;
      if (!rst_n) begin
        pending  = 1'b0;
        req_wait = 0;
      end else if (rd) begin
        if (req_wait == ack_dly) begin
          ack = 1'b1; req_wait = 0; pending = 1'b1;
        end else begin
          req_wait++;
        end
      end else if (pending) begin
        pending = 1'b0;
        if (rd_idx != hold_idx) begin
          rdy = 1'b1;
          din = shuf(addr) ^ ((corrupt_en && (addr == 22'd1 || addr == 22'd3)) ? 16'h0100 : 16'h0000);
        end
        rd_idx++;
      end
    end
  end

  // monitor: address/reference at each REQ start, rd lengths, done pulses
  logic [21:0] alog[$];
  logic [15:0] rlog[$];
  int          rd_len[$];
  int          done_cnt = 0;
  int          cur_len  = 0;
  logic        prev_rd  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rd) begin
        if (!prev_rd) begin
          alog.push_back(addr);
          rlog.push_back(ref_raw);
          cur_len = 0;
        end
        cur_len++;
      end else if (prev_rd) begin
        rd_len.push_back(cur_len);
      end
      prev_rd = rd;
    end
  end

  task automatic clear_logs();
    alog.delete(); rlog.delete(); rd_len.delete();
    rd_idx = 0;
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    start = 1'b1; rnd = m;
    @(negedge clk);
    start = 1'b0; rnd = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int k;
    k = 0;
    while (done_cnt == base && k < 2000) begin
      @(posedge clk);
      k++;
    end
    check(tag, (done_cnt != base), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef JTSDRAM_TIMEOUT_EN
  logic        start0, rd0, ack0, rdy0, busy0, done0, bad0;
  logic [21:0] addr0;
  logic [15:0] ref_raw0, ref_shf0, din0, err_cnt0;
  assign ref_shf0 = shuf(addr0);
  jtsdram_rdcheck #(.LAST(22'd0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rnd(1'b0),
    .addr(addr0), .ref_raw(ref_raw0), .ref_shf(ref_shf0),
    .rd(rd0), .ack(ack0), .rdy(rdy0), .din(din0),
    .busy(busy0), .done(done0), .bad(bad0), .err_cnt(err_cnt0)
  );
  initial begin
    start0 = 1'b0; ack0 = 1'b1; rdy0 = 1'b0; din0 = 16'd0;
  end
`endif

  initial begin
    int base, k;
    rst_n = 1'b0; start = 1'b0; rnd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", addr, 0);
    check("rst_ref_raw", ref_raw, 0);
    check("rst_rd", rd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bad", bad, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;

    // linear pass with start-to-rd timing
    clear_logs();
    base = done_cnt;
    @(negedge clk); start = 1'b1; rnd = 1'b0;
    @(posedge clk); #1;
    check("start_busy", busy, 1);
    check("start_rd_n1", rd, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check("start_rd_n2", rd, 1);
    wait_done(base, "lin_done_seen");
    check("lin_nreads", alog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lin_addr%0d", i), alog[i], i);
      check($sformatf("lin_ref%0d", i), rlog[i], i);
    end
    check("lin_bad", bad, 0);
    check("lin_err", err_cnt, 0);
    repeat (5) @(posedge clk); #1;
    check("lin_done_once", done_cnt, base + 1);
    check("lin_idle", busy, 0);

    // LFSR pass
    clear_logs();
    base = done_cnt;
    @(negedge clk); start = 1'b1; rnd = 1'b1;
    @(posedge clk); #1;
    check("lfsr_first", addr, 1);
    start = 1'b0; rnd = 1'b0;
    wait_done(base, "lfsr_done_seen");
    check("lfsr_nreads", alog.size(), 4);
    check("lfsr_a0", alog[0], 22'd1);
    check("lfsr_a1", alog[1], 22'd2);
    check("lfsr_a2", alog[2], 22'd4);
    check("lfsr_a3", alog[3], 22'd8);
    check("lfsr_bad", bad, 0);

    // corrupted reads at addresses 1 and 3, then a clean pass
    clear_logs();
    corrupt_en = 1'b1;
    base = done_cnt;
    pulse_start(1'b0);
    wait_done(base, "cor_done_seen");
    check("cor_err", err_cnt, 2);
    check("cor_bad", bad, 1);
    repeat (4) @(posedge clk); #1;
    check("cor_err_hold", err_cnt, 2);
    corrupt_en = 1'b0;
    clear_logs();
    base = done_cnt;
    pulse_start(1'b0);
    #1;
    check("clean_bad_clr", bad, 0);
    check("clean_err_clr", err_cnt, 0);
    wait_done(base, "clean_done_seen");
    check("clean_err", err_cnt, 0);

    // delayed ack plus ignored start during REQ
    clear_logs();
    ack_dly = 5;
    base = done_cnt;
    pulse_start(1'b0);
    k = 0;
    while (!rd && k < 50) begin @(posedge clk); #1; k++; end
    check("dly_rd_seen", rd, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(base, "dly_done_seen");
    check("dly_len0", rd_len[0], 6);
    check("dly_len3", rd_len[3], 6);
    check("dly_nreads", alog.size(), 4);
    repeat (5) @(posedge clk); #1;
    check("dly_no_restart", busy, 0);
    check("dly_done_once", done_cnt, base + 1);
    ack_dly = 0;

    // reset during WAIT of read 2
    clear_logs();
    hold_idx = 2;
    pulse_start(1'b0);
    k = 0;
    while (!(alog.size() == 3 && !rd) && k < 200) begin @(posedge clk); #1; k++; end
    check("rstw_in_wait", (alog.size() == 3 && !rd && busy), 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_addr", addr, 0);
    check("rstw_ref_raw", ref_raw, 0);
    check("rstw_rd", rd, 0);
    check("rstw_busy", busy, 0);
    check("rstw_done", done, 0);
    check("rstw_bad", bad, 0);
    check("rstw_err", err_cnt, 0);
    base = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_idx = -1;
    repeat (10) @(posedge clk); #1;
    check("rstw_no_done", done_cnt, base);
    clear_logs();
    pulse_start(1'b0);
    wait_done(base, "rstw_restart_done");
    check("rstw_restart_a0", alog[0], 0);
    check("rstw_restart_n", alog.size(), 4);

`ifdef JTSDRAM_TIMEOUT_EN
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    k = 0;
    while (!rd0 && k < 20) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    check("tmo_in_wait", (busy0 && !rd0), 1);
    k = 0;
    while (!done0 && k < 1000) begin @(posedge clk); #1; k++; end
    check("tmo_latency", k, 256);
    check("tmo_err", err_cnt0, 1);
    check("tmo_bad", bad0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
